if_fetch_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pc_next_sel.sv | 63 ++++++
 rtl/if_fetch_stage.sv | 108 ++++++++++
 tb/tb_if_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM encodings,
// pipeline register widths, the IF/ID record and a word-alignment helper.
package pipe_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    post_pc;
        logic               valid;
    } ifid_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage: picks branch, halt, stall, jump or
// sequential flow and produces the PC-load and IF/ID load/flush controls.
module pc_next_sel
    import pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_STEP = 32'd4
) (
    input  fetch_state_e    i_state,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_halt,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_target,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    output logic [PC_W-1:0] o_next_pc,
    output logic [PC_W-1:0] o_seq_pc,
    output logic            o_pc_load,
    output logic            o_ifid_load,
    output logic            o_ifid_bubble,
    output logic            o_enter_halt
);

    logic [PC_W-1:0] w_seq_pc;

    assign w_seq_pc = word_align(i_pc + PC_STEP);
    assign o_seq_pc = w_seq_pc;

    // Redirect priority in RUN; BOOT, HALT and the unused encoding load a bubble and hold PC.
    always_comb begin
        o_next_pc     = i_pc;
        o_pc_load     = 1'b0;
        o_ifid_load   = 1'b1;
        o_ifid_bubble = 1'b1;
        o_enter_halt  = 1'b0;
        case (i_state)
            FS_RUN: begin
                if (i_branch_taken) begin
                    // A halt in the same cycle must not lose the branch redirect.
                    o_next_pc    = word_align(i_branch_target);
                    o_pc_load    = 1'b1;
                    o_enter_halt = i_halt;
                end else if (i_halt) begin
                    o_enter_halt = 1'b1;
                end else if (i_stall) begin
                    o_ifid_load   = 1'b0;
                    o_ifid_bubble = 1'b0;
                end else if (i_jump) begin
                    o_next_pc = word_align(i_jump_target);
                    o_pc_load = 1'b1;
                end else begin
                    o_next_pc     = w_seq_pc;
                    o_pc_load     = 1'b1;
                    o_ifid_bubble = 1'b0;
                end
            end
            default: begin
                o_next_pc = i_pc;
            end
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control FSM and the
// IF/ID pipeline register holding the fetched word and its PC+4.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inStall,
    input  logic               inHalt,
    input  logic               inJump,
    input  logic [PC_W-1:0]    inJumpTarget,
    input  logic               inBranchTaken,
    input  logic [PC_W-1:0]    inBranchTarget,
    input  logic [INSTR_W-1:0] inImemData,
    output logic [PC_W-1:0]    outImemAddr,
    output logic [INSTR_W-1:0] outInstruction,
    output logic [PC_W-1:0]    outPostPc,
    output logic               outValid,
    output logic [1:0]         outState
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [PC_W-1:0] r_pc;
    ifid_t           r_ifid;

    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_seq_pc;
    logic            w_pc_load;
    logic            w_ifid_load;
    logic            w_ifid_bubble;
    logic            w_enter_halt;

    pc_next_sel #(
        .PC_STEP (PC_STEP)
    ) u_pc_next_sel (
        .i_state         (r_state),
        .i_pc            (r_pc),
        .i_stall         (inStall),
        .i_halt          (inHalt),
        .i_jump          (inJump),
        .i_jump_target   (inJumpTarget),
        .i_branch_taken  (inBranchTaken),
        .i_branch_target (inBranchTarget),
        .o_next_pc       (w_next_pc),
        .o_seq_pc        (w_seq_pc),
        .o_pc_load       (w_pc_load),
        .o_ifid_load     (w_ifid_load),
        .o_ifid_bubble   (w_ifid_bubble),
        .o_enter_halt    (w_enter_halt)
    );

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next state; only reset leaves HALT.
    always_comb begin
        w_state_next = FS_BOOT;
        case (r_state)
            FS_BOOT: w_state_next = FS_RUN;
            FS_RUN:  w_state_next = w_enter_halt ? FS_HALT : FS_RUN;
            FS_HALT: w_state_next = FS_HALT;
            default: w_state_next = FS_BOOT;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= word_align(RESET_PC);
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end else begin
            r_pc <= r_pc;
        end
    end

    // IF/ID register; a bubble clears the whole record so nothing undefined leaks downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid <= '{instr: NOP_WORD, post_pc: {PC_W{1'b0}}, valid: 1'b0};
        end else if (w_ifid_load) begin
            if (w_ifid_bubble) begin
                r_ifid <= '{instr: NOP_WORD, post_pc: {PC_W{1'b0}}, valid: 1'b0};
            end else begin
                r_ifid <= '{instr: inImemData, post_pc: w_seq_pc, valid: 1'b1};
            end
        end else begin
            r_ifid <= r_ifid;
        end
    end

    assign outImemAddr    = r_pc;
    assign outInstruction = r_ifid.instr;
    assign outPostPc      = r_ifid.post_pc;
    assign outValid       = r_ifid.valid;
    assign outState       = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a behavioural fetch model pushes the
// expected post-edge state into a queue, a monitor pops and compares every cycle.
module tb_if_fetch_stage;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inStall = 1'b0;
    logic        inHalt = 1'b0;
    logic        inJump = 1'b0;
    logic [31:0] inJumpTarget = 32'h0;
    logic        inBranchTaken = 1'b0;
    logic [31:0] inBranchTarget = 32'h0;
    logic [31:0] inImemData;
    logic [31:0] outImemAddr;
    logic [31:0] outInstruction;
    logic [31:0] outPostPc;
    logic        outValid;
    logic [1:0]  outState;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] post;
        logic        valid;
        logic [1:0]  state;
    } snap_t;

    snap_t       sb_q[$];
    snap_t       mon_e;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_post;
    logic        m_valid;
    logic [1:0]  m_state;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inStall        (inStall),
        .inHalt         (inHalt),
        .inJump         (inJump),
        .inJumpTarget   (inJumpTarget),
        .inBranchTaken  (inBranchTaken),
        .inBranchTarget (inBranchTarget),
        .inImemData     (inImemData),
        .outImemAddr    (outImemAddr),
        .outInstruction (outInstruction),
        .outPostPc      (outPostPc),
        .outValid       (outValid),
        .outState       (outState)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2001_0005 : (a ^ 32'h5A5A_0000);
    endfunction

    assign inImemData = imem(outImemAddr);

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_post = 32'h0; m_valid = 1'b0; m_state = S_BOOT;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_post = 32'h0; m_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then advance past the edge.
    task automatic cycle(input logic st, input logic hl, input logic jp, input logic [31:0] jt,
                         input logic br, input logic [31:0] bt);
        inStall = st; inHalt = hl; inJump = jp; inJumpTarget = jt;
        inBranchTaken = br; inBranchTarget = bt;
        if (m_state == S_RUN) begin
            if (br) begin
                m_pc = bt & 32'hFFFF_FFFC; model_bubble();
                if (hl) m_state = S_HALT;
            end else if (hl) begin
                model_bubble(); m_state = S_HALT;
            end else if (st) begin
                m_pc = m_pc;
            end else if (jp) begin
                m_pc = jt & 32'hFFFF_FFFC; model_bubble();
            end else begin
                m_instr = imem(m_pc); m_post = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (m_state == S_BOOT) begin
            model_bubble(); m_state = S_RUN;
        end else begin
            model_bubble();
        end
        sb_q.push_back('{pc: m_pc, instr: m_instr, post: m_post, valid: m_valid, state: m_state});
        @(posedge clk);
        #2;
    endtask

    // Scoreboard consumer: one expected snapshot per clock edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({outImemAddr, outInstruction, outPostPc, outValid, outState} !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got pc=%h ins=%h post=%h v=%b st=%0d exp pc=%h ins=%h post=%h v=%b st=%0d",
                         $time, outImemAddr, outInstruction, outPostPc, outValid, outState,
                         mon_e.pc, mon_e.instr, mon_e.post, mon_e.valid, mon_e.state);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; model_reset();
        #3;
        checks++; if (outImemAddr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", outImemAddr, 32'h0); end
        checks++; if ({outInstruction, outPostPc, outValid} !== 65'h0) begin errors++; $display("FAIL reset_ifid got %h %h %b exp zeros", outInstruction, outPostPc, outValid); end
        checks++; if (outState !== S_BOOT) begin errors++; $display("FAIL reset_state got %0d exp %0d", outState, S_BOOT); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", outValid); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (outImemAddr !== 32'h4) begin errors++; $display("FAIL first_pc got %h exp %h", outImemAddr, 32'h4); end
        checks++; if (outInstruction !== 32'h2001_0005) begin errors++; $display("FAIL first_instr got %h exp %h", outInstruction, 32'h2001_0005); end
        checks++; if ({outPostPc, outValid} !== {32'h4, 1'b1}) begin errors++; $display("FAIL first_post got %h/%b exp 4/1", outPostPc, outValid); end
    endtask

    task automatic test_jump();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (outImemAddr !== 32'h8) begin errors++; $display("FAIL jump_setup_pc got %h exp %h", outImemAddr, 32'h8); end
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 32'h0);
        checks++; if ({outImemAddr, outValid} !== {32'h0040_0020, 1'b0}) begin errors++; $display("FAIL jump_pc got %h/%b exp 00400020/0", outImemAddr, outValid); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (outPostPc !== 32'h0040_0024) begin errors++; $display("FAIL jump_post got %h exp %h", outPostPc, 32'h0040_0024); end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_000C);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'h0000_0777, 1'b0, 32'h0);
            checks++; if (outImemAddr !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, outImemAddr, 32'h10); end
            checks++;
            if ({outInstruction, outPostPc, outValid} !== {imem(32'hC), 32'h10, 1'b1}) begin
                errors++; $display("FAIL stall_ifid[%0d] got %h %h %b exp %h 00000010 1", i, outInstruction, outPostPc, outValid, imem(32'hC));
            end
        end
    endtask

    task automatic test_branch_priority();
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100);
        checks++; if ({outImemAddr, outValid} !== {32'h100, 1'b0}) begin errors++; $display("FAIL branch_prio got %h/%b exp 00000100/0", outImemAddr, outValid); end
    endtask

    task automatic test_wrap_align();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if ({outImemAddr, outPostPc, outValid} !== {32'h0, 32'h0, 1'b1}) begin errors++; $display("FAIL wrap got pc=%h post=%h v=%b exp 0/0/1", outImemAddr, outPostPc, outValid); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
        checks++; if (outImemAddr !== 32'h100) begin errors++; $display("FAIL align got %h exp %h", outImemAddr, 32'h100); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            cycle(($urandom_range(3) == 0), 1'b0, ($urandom_range(3) == 0), $urandom,
                  ($urandom_range(7) == 0), $urandom);
        end
    endtask

    task automatic test_halt();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
        checks++; if ({outState, outImemAddr, outValid} !== {S_HALT, 32'h200, 1'b0}) begin errors++; $display("FAIL halt_enter got st=%0d pc=%h v=%b exp 2/00000200/0", outState, outImemAddr, outValid); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, $urandom, 1'b1, $urandom);
            checks++; if ({outState, outImemAddr, outValid} !== {S_HALT, 32'h200, 1'b0}) begin errors++; $display("FAIL halt_hold[%0d] got st=%0d pc=%h v=%b", i, outState, outImemAddr, outValid); end
        end
        #2;
        rst_n = 1'b0; model_reset();
        #1;
        checks++; if ({outState, outImemAddr, outValid, outInstruction} !== {S_BOOT, 32'h0, 1'b0, 32'h0}) begin errors++; $display("FAIL async_reset got st=%0d pc=%h v=%b ins=%h", outState, outImemAddr, outValid, outInstruction); end
        #1;
        rst_n = 1'b1;
        inStall = 1'b0; inHalt = 1'b0; inJump = 1'b0; inBranchTaken = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if ({outState, outImemAddr, outValid} !== {S_RUN, 32'h0, 1'b0}) begin errors++; $display("FAIL restart_boot got st=%0d pc=%h v=%b", outState, outImemAddr, outValid); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
        checks++; if ({outState, outImemAddr} !== {S_HALT, 32'h4}) begin errors++; $display("FAIL halt_only got st=%0d pc=%h exp 2/00000004", outState, outImemAddr); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_stall();
        test_branch_priority();
        test_wrap_align();
        test_random();
        test_halt();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
